// File: rtl/output_drain.sv
// output_drain: serialises MAC tiles (NB_LANES signed accumulator results) into a
// stream of narrowed output samples, one lane per output_valid/output_ready handshake.
//
// Two tile slots are held. DRAIN is the tile whose lanes are being emitted, and
// PENDING is a waiting tile. When DRAIN's last lane handshakes, PENDING (or a tile
// accepted in the same cycle) moves straight in, so back-to-back tiles have no bubble.
//
// Each sample is out = narrow(lane >>> OUTPUT_SCALE), using an arithmetic shift.
// The build macro OUTPUT_DRAIN_SATURATE_EN selects how narrow() behaves:
//   defined   : narrow() clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]
//   undefined : narrow() keeps the low DATA_WIDTH bits (two's-complement wrap)
//
// Ports
//   clk, rst_in        : clock and synchronous active-high reset
//   tile_in            : NB_LANES x ACC_WIDTH signed lanes, lane k at [k*ACC_WIDTH +: ACC_WIDTH]
//   tile_x/y/ch_base   : coordinates of the tile, captured when the tile is accepted
//   tile_valid/ready   : tile handshake; tile_ready = !PENDING_full
//   out, output_valid  : sample stream; output_ready from the consumer
//   output_x/y/ch      : sample coordinates; ch = tile_ch_base + lane, modulo its width
//   tile_done          : one-cycle pulse on the final lane handshake of a tile

module output_drain #(
  parameter int unsigned DATA_WIDTH         = 16,
  parameter int unsigned ACC_WIDTH          = 32,
  parameter int unsigned NB_LANES           = 16,
  parameter int unsigned OUTPUT_SCALE       = 0,
  parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
  parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
  parameter int unsigned OUTPUT_NB_CHANNELS = 64,
  localparam int unsigned XW = (FEATURE_MAP_WIDTH > 1) ? $clog2(FEATURE_MAP_WIDTH) : 1,
  localparam int unsigned YW = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
  localparam int unsigned CW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_in,
  input  logic [NB_LANES*ACC_WIDTH-1:0]  tile_in,
  input  logic [XW-1:0]                  tile_x,
  input  logic [YW-1:0]                  tile_y,
  input  logic [CW-1:0]                  tile_ch_base,
  input  logic                           tile_valid,
  output logic                           tile_ready,
  output logic signed [DATA_WIDTH-1:0]   out,
  output logic                           output_valid,
  input  logic                           output_ready,
  output logic [XW-1:0]                  output_x,
  output logic [YW-1:0]                  output_y,
  output logic [CW-1:0]                  output_ch,
  output logic                           tile_done
);

  localparam int unsigned LW = (NB_LANES > 1) ? $clog2(NB_LANES) : 1;

  typedef logic [NB_LANES-1:0][ACC_WIDTH-1:0] tile_t;

  // DRAIN slot
  logic          drain_full_q, drain_full_d;
  tile_t         drain_data_q, drain_data_d;
  logic [XW-1:0] drain_x_q, drain_x_d;
  logic [YW-1:0] drain_y_q, drain_y_d;
  logic [CW-1:0] drain_ch_q, drain_ch_d;

  // PENDING slot
  logic          pend_full_q, pend_full_d;
  tile_t         pend_data_q, pend_data_d;
  logic [XW-1:0] pend_x_q, pend_x_d;
  logic [YW-1:0] pend_y_q, pend_y_d;
  logic [CW-1:0] pend_ch_q, pend_ch_d;

  // Lane counter within the DRAIN tile
  logic [LW-1:0] lane_q, lane_d;

  logic accept;
  logic hs;
  logic last_hs;
  logic drain_free;

  // Shift then narrow one accumulator lane to the sample width.
  function automatic logic signed [DATA_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] v);
`ifdef OUTPUT_DRAIN_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] SatMax =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SatMin =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    logic signed [ACC_WIDTH-1:0] s;
    s = v >>> OUTPUT_SCALE;
    if (s > SatMax) begin
      narrow = SatMax[DATA_WIDTH-1:0];
    end else if (s < SatMin) begin
      narrow = SatMin[DATA_WIDTH-1:0];
    end else begin
      narrow = s[DATA_WIDTH-1:0];
    end
`else
    narrow = DATA_WIDTH'(v >>> OUTPUT_SCALE);
`endif
  endfunction

  // Handshake decode. Reset masks the stream and the accept path so that nothing
  // moves in the reset cycle, and tile_ready reads 1 while reset is held.
  assign tile_ready   = !pend_full_q || rst_in;
  assign output_valid = drain_full_q && !rst_in;
  assign accept       = tile_valid && !pend_full_q && !rst_in;
  assign hs           = output_valid && output_ready;
  assign last_hs      = hs && (lane_q == LW'(NB_LANES - 1));
  assign drain_free   = !drain_full_q || last_hs;
  assign tile_done    = last_hs;

  // Outputs come from registered slot state only, so they hold steady under stall.
  // They are forced to zero while no sample is offered.
  always_comb begin
    out       = '0;
    output_x  = '0;
    output_y  = '0;
    output_ch = '0;
    if (output_valid) begin
      out       = narrow(drain_data_q[lane_q]);
      output_x  = drain_x_q;
      output_y  = drain_y_q;
      output_ch = drain_ch_q + CW'(lane_q);
    end
  end

  always_comb begin
    drain_full_d = drain_full_q;
    drain_data_d = drain_data_q;
    drain_x_d    = drain_x_q;
    drain_y_d    = drain_y_q;
    drain_ch_d   = drain_ch_q;
    pend_full_d  = pend_full_q;
    pend_data_d  = pend_data_q;
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
    pend_ch_d    = pend_ch_q;
    lane_d       = lane_q;

    if (hs) begin
      lane_d = last_hs ? '0 : lane_q + LW'(1);
    end

    if (drain_free) begin
      if (pend_full_q) begin
        // PENDING is older than anything on the input; tile_ready is low here,
        // so no new tile can arrive in this cycle.
        drain_full_d = 1'b1;
        drain_data_d = pend_data_q;
        drain_x_d    = pend_x_q;
        drain_y_d    = pend_y_q;
        drain_ch_d   = pend_ch_q;
        pend_full_d  = 1'b0;
      end else if (accept) begin
        drain_full_d = 1'b1;
        drain_data_d = tile_in;
        drain_x_d    = tile_x;
        drain_y_d    = tile_y;
        drain_ch_d   = tile_ch_base;
      end else begin
        drain_full_d = 1'b0;
      end
    end else if (accept) begin
      pend_full_d = 1'b1;
      pend_data_d = tile_in;
      pend_x_d    = tile_x;
      pend_y_d    = tile_y;
      pend_ch_d   = tile_ch_base;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      drain_full_q <= 1'b0;
      drain_data_q <= '0;
      drain_x_q    <= '0;
      drain_y_q    <= '0;
      drain_ch_q   <= '0;
      pend_full_q  <= 1'b0;
      pend_data_q  <= '0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      pend_ch_q    <= '0;
      lane_q       <= '0;
    end else begin
      drain_full_q <= drain_full_d;
      drain_data_q <= drain_data_d;
      drain_x_q    <= drain_x_d;
      drain_y_q    <= drain_y_d;
      drain_ch_q   <= drain_ch_d;
      pend_full_q  <= pend_full_d;
      pend_data_q  <= pend_data_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      pend_ch_q    <= pend_ch_d;
      lane_q       <= lane_d;
    end
  end

endmodule

// File: tb/tb_output_drain.sv
// Directed testbench for output_drain. Two instances share all inputs: dut uses
// OUTPUT_SCALE=0 and dut4 uses OUTPUT_SCALE=4. Inputs change 1ns after the rising
// edge, and outputs are sampled on the falling edge.

module tb_output_drain;

  logic         clk;
  logic         rst_in;
  logic [511:0] tile_in;
  logic [9:0]   tile_x;
  logic [9:0]   tile_y;
  logic [5:0]   tile_ch_base;
  logic         tile_valid;
  logic         output_ready;

  logic                tile_ready, output_valid, tile_done;
  logic signed [15:0]  out;
  logic [9:0]          output_x, output_y;
  logic [5:0]          output_ch;

  logic                s4_tile_ready, s4_output_valid, s4_tile_done;
  logic signed [15:0]  s4_out;
  logic [9:0]          s4_output_x, s4_output_y;
  logic [5:0]          s4_output_ch;

  int errors = 0;
  int checks = 0;

  output_drain dut (
    .clk          (clk),
    .rst_in       (rst_in),
    .tile_in      (tile_in),
    .tile_x       (tile_x),
    .tile_y       (tile_y),
    .tile_ch_base (tile_ch_base),
    .tile_valid   (tile_valid),
    .tile_ready   (tile_ready),
    .out          (out),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_x     (output_x),
    .output_y     (output_y),
    .output_ch    (output_ch),
    .tile_done    (tile_done)
  );

  output_drain #(.OUTPUT_SCALE(4)) dut4 (
    .clk          (clk),
    .rst_in       (rst_in),
    .tile_in      (tile_in),
    .tile_x       (tile_x),
    .tile_y       (tile_y),
    .tile_ch_base (tile_ch_base),
    .tile_valid   (tile_valid),
    .tile_ready   (s4_tile_ready),
    .out          (s4_out),
    .output_valid (s4_output_valid),
    .output_ready (output_ready),
    .output_x     (s4_output_x),
    .output_y     (s4_output_y),
    .output_ch    (s4_output_ch),
    .tile_done    (s4_tile_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end

  // Lane k = base + stride*k.
  function automatic logic [511:0] mk_tile(input int base, input int stride);
    logic [511:0] t;
    t = '0;
    for (int k = 0; k < 16; k++) t[k*32 +: 32] = 32'(base + stride * k);
    return t;
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_in = 1'b1; tile_valid = 1'b0; output_ready = 1'b0;
    tile_in = '0; tile_x = '0; tile_y = '0; tile_ch_base = '0;
    next_cycle(); next_cycle();
    @(negedge clk);
    checks++;
    if ({output_valid, out, output_x, output_y, output_ch, tile_done, tile_ready} !==
        {1'b0, 16'd0, 10'd0, 10'd0, 6'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_during: v=%b out=%0d x=%0d y=%0d ch=%0d done=%b rdy=%b (want 0,0,0,0,0,0,1)",
               output_valid, out, output_x, output_y, output_ch, tile_done, tile_ready);
    end
    next_cycle();
    rst_in = 1'b0;
    @(negedge clk);
    checks++;
    if ({output_valid, out, output_ch, tile_done, tile_ready, s4_output_valid} !==
        {1'b0, 16'd0, 6'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_after: v=%b out=%0d ch=%0d done=%b rdy=%b v4=%b",
               output_valid, out, output_ch, tile_done, tile_ready, s4_output_valid);
    end
    next_cycle();
  endtask

  task automatic test_single;
    tile_valid = 1'b1; tile_in = mk_tile(-8, 1);
    tile_x = 10'd5; tile_y = 10'd7; tile_ch_base = 6'd16; output_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({tile_ready, output_valid} !== 2'b10) begin
      errors++;
      $display("FAIL single_accept: rdy=%b v=%b (want 1,0)", tile_ready, output_valid);
    end
    next_cycle();
    // Changes after acceptance must not reach the stream.
    tile_valid = 1'b0; tile_in = mk_tile(999, 3);
    tile_x = 10'd1; tile_y = 10'd2; tile_ch_base = 6'd3;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if ({output_valid, out, output_x, output_y, output_ch, tile_done} !==
          {1'b1, 16'(k - 8), 10'd5, 10'd7, 6'(16 + k), 1'(k == 15)}) begin
        errors++;
        $display("FAIL single_lane%0d: v=%b out=%0d x=%0d y=%0d ch=%0d done=%b (want 1,%0d,5,7,%0d,%0d)",
                 k, output_valid, out, output_x, output_y, output_ch, tile_done,
                 k - 8, 16 + k, k == 15);
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if ({output_valid, tile_done} !== 2'b00) begin
      errors++;
      $display("FAIL single_end: v=%b done=%b (want 0,0)", output_valid, tile_done);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back;
    int offs[3];
    int bases[3];
    int idx;
    int n;
    int t;
    int l;
    logic acc;
    logic exp_rdy;
    logic exp_v;
    offs = '{0, 100, 200};
    bases = '{0, 16, 32};
    idx = 0;
    output_ready = 1'b1;
    for (int c = 0; c <= 50; c++) begin
      tile_valid = (idx < 3);
      if (idx < 3) begin
        tile_in = mk_tile(offs[idx], 1);
        tile_x = 10'(idx + 1); tile_y = 10'd3; tile_ch_base = 6'(bases[idx]);
      end
      @(negedge clk);
      exp_rdy = !((c >= 2 && c <= 16) || (c >= 18 && c <= 32));
      exp_v = (c >= 1 && c <= 48);
      checks++;
      if ({tile_ready, output_valid} !== {exp_rdy, exp_v}) begin
        errors++;
        $display("FAIL b2b_ctrl c=%0d: rdy=%b v=%b (want %b,%b)",
                 c, tile_ready, output_valid, exp_rdy, exp_v);
      end
      if (exp_v) begin
        n = c - 1; t = n / 16; l = n % 16;
        checks++;
        if ({out, output_x, output_ch, tile_done} !==
            {16'(offs[t] + l), 10'(t + 1), 6'(bases[t] + l), 1'(l == 15)}) begin
          errors++;
          $display("FAIL b2b_data c=%0d: out=%0d x=%0d ch=%0d done=%b (want %0d,%0d,%0d,%0d)",
                   c, out, output_x, output_ch, tile_done, offs[t] + l, t + 1,
                   bases[t] + l, l == 15);
        end
      end
      acc = tile_valid && tile_ready;
      next_cycle();
      if (acc) idx++;
    end
    tile_valid = 1'b0;
  endtask

  task automatic test_stall;
    int n;
    logic rd;
    tile_valid = 1'b1; tile_in = mk_tile(-20, 3);
    tile_x = 10'd9; tile_y = 10'd11; tile_ch_base = 6'd60; output_ready = 1'b0;
    next_cycle();
    tile_valid = 1'b0; tile_in = '0;
    n = 0;
    for (int c = 0; c < 80 && n < 16; c++) begin
      rd = (c % 4 == 0) || (c % 4 == 3);
      output_ready = rd;
      @(negedge clk);
      checks++;
      // Channel 60+n wraps modulo 64.
      if ({output_valid, out, output_x, output_y, output_ch, tile_done} !==
          {1'b1, 16'(-20 + 3 * n), 10'd9, 10'd11, 6'(60 + n), 1'(rd && n == 15)}) begin
        errors++;
        $display("FAIL stall c=%0d lane%0d: v=%b out=%0d ch=%0d done=%b (want 1,%0d,%0d,%0d)",
                 c, n, output_valid, out, output_ch, tile_done, -20 + 3 * n,
                 (60 + n) % 64, rd && n == 15);
      end
      if (rd) n++;
      next_cycle();
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL stall_timeout: lanes=%0d (want 16)", n);
    end
    @(negedge clk);
    checks++;
    if (output_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: v=%b (want 0)", output_valid);
    end
    output_ready = 1'b1;
    next_cycle();
  endtask

  task automatic test_narrow;
    logic [15:0] expv[4];
`ifdef OUTPUT_DRAIN_SATURATE_EN
    expv = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
`else
    expv = '{16'h2345, 16'h0000, 16'h7FFF, 16'h8000};
`endif
    tile_in = '0;
    tile_in[31:0]   = 32'h0001_2345;
    tile_in[63:32]  = 32'hFFFF_0000;
    tile_in[95:64]  = 32'h0000_7FFF;
    tile_in[127:96] = 32'hFFFF_8000;
    tile_valid = 1'b1; tile_ch_base = 6'd0; output_ready = 1'b1;
    next_cycle();
    tile_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k < 4) begin
        checks++;
        if ({output_valid, out} !== {1'b1, expv[k]}) begin
          errors++;
          $display("FAIL narrow_lane%0d: v=%b out=%h (want 1,%h)", k, output_valid, out, expv[k]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_scale;
    logic [15:0] expv[5];
`ifdef OUTPUT_DRAIN_SATURATE_EN
    expv = '{16'hFFFD, 16'h0002, 16'hFFFF, 16'h7FFF, 16'hFFFE};
`else
    expv = '{16'hFFFD, 16'h0002, 16'hFFFF, 16'h8000, 16'hFFFE};
`endif
    tile_in = '0;
    tile_in[31:0]    = 32'hFFFF_FFDF;  // -33
    tile_in[63:32]   = 32'd32;
    tile_in[95:64]   = 32'hFFFF_FFFF;  // -1
    tile_in[127:96]  = 32'h0008_0000;
    tile_in[159:128] = 32'hFFFF_FFEF;  // -17
    tile_valid = 1'b1; output_ready = 1'b1;
    next_cycle();
    tile_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (out !== 16'hFFDF) begin
          errors++;
          $display("FAIL scale0_lane0: out=%0d (want -33)", out);
        end
      end
      if (k < 5) begin
        checks++;
        if ({s4_output_valid, s4_out} !== {1'b1, expv[k]}) begin
          errors++;
          $display("FAIL scale4_lane%0d: v=%b out=%h (want 1,%h)", k, s4_output_valid, s4_out,
                   expv[k]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid;
    logic stale;
    output_ready = 1'b1;
    tile_valid = 1'b1; tile_in = mk_tile(50, 1); tile_ch_base = 6'd0;
    next_cycle();
    tile_in = mk_tile(500, 1);
    @(negedge clk);
    checks++;
    if ({tile_ready, output_valid, out} !== {1'b1, 1'b1, 16'd50}) begin
      errors++;
      $display("FAIL rmid_start: rdy=%b v=%b out=%0d (want 1,1,50)", tile_ready, output_valid, out);
    end
    next_cycle();
    tile_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({tile_ready, output_valid, out} !== {1'b0, 1'b1, 16'(50 + k)}) begin
        errors++;
        $display("FAIL rmid_lane%0d: rdy=%b v=%b out=%0d (want 0,1,%0d)",
                 k, tile_ready, output_valid, out, 50 + k);
      end
      next_cycle();
    end
    rst_in = 1'b1;
    next_cycle();
    rst_in = 1'b0;
    @(negedge clk);
    checks++;
    if ({output_valid, tile_ready, tile_done, out} !== {1'b0, 1'b1, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL rmid_after: v=%b rdy=%b done=%b out=%0d (want 0,1,0,0)",
               output_valid, tile_ready, tile_done, out);
    end
    next_cycle();
    stale = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (output_valid !== 1'b0 || tile_ready !== 1'b1) stale = 1'b1;
      next_cycle();
    end
    checks++;
    if (stale !== 1'b0) begin
      errors++;
      $display("FAIL rmid_stale: stale lanes or busy after reset=%b (want 0)", stale);
    end
    tile_valid = 1'b1; tile_in = mk_tile(7, 2); tile_ch_base = 6'd4; tile_x = 10'd2;
    next_cycle();
    tile_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if ({output_valid, out, output_ch, tile_done} !==
          {1'b1, 16'(7 + 2 * k), 6'(4 + k), 1'(k == 15)}) begin
        errors++;
        $display("FAIL rmid_new_lane%0d: v=%b out=%0d ch=%0d done=%b (want 1,%0d,%0d,%0d)",
                 k, output_valid, out, output_ch, tile_done, 7 + 2 * k, 4 + k, k == 15);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_narrow();
    test_scale();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
